tlb_miss_queue: RTL and testbench
=================================

Name: tlb_miss_queue

Overview:
- Upstream feeder for the page-table walker.
- Collects TLB misses from the instruction-side and data-side TLBs into a small FIFO and drops duplicate pages.
- Issues one walk at a time over the walker's new_en/new_can handshake, then holds the next issue until the walker signals completion (its TLB-write ready pulse).

Parameters:
DEPTH, 4, number of queued miss entries (power of two, >=2)
CNT_W, 3, width of occupancy count (log2(DEPTH)+1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
except  in  1  pipeline flush; discards all queued (not in-flight) entries
i_req_en  in  1  instruction-TLB miss request
i_req_addr  in  48  virtual address of code miss
i_req_attr  in  4  attribute bits of code miss
i_req_can  out  1  code request may be presented this cycle
d_req_en  in  1  data-TLB miss request
d_req_addr  in  48  virtual address of data miss
d_req_attr  in  4  attribute bits of data miss
d_req_indir  in  1  indirect flag for data miss
d_req_inv  in  1  invalidate request (no walk; pager installs non-present entry)
d_req_can  out  1  data request may be presented this cycle
new_en  out  1  walk request valid to pager
new_can  in  1  pager ready to accept
new_addr  out  48  head entry address
new_attr  out  4  head entry attributes
new_indir  out  1  head entry indirect flag
new_inv  out  1  head entry invalidate flag
new_permReq  out  1  1 = code walk, 0 = data walk
walk_done  in  1  one-cycle pulse from pager when TLB write data is ready
busy  out  1  queue non-empty or walk in flight
count  out  CNT_W  queued entries (excludes in-flight)

Behaviour:
- Reset (rst low, async): count=0, all entry valids=0, in-flight=0, new_en=0, new_addr/attr/indir/inv/permReq=0, busy=0.
- Entry fields: addr[47:0], attr, indir, inv, permReq. Code entries store indir=0, inv=0, permReq=1.
- Match key: addr[47:14], attr, permReq, inv.
- Capacity:
  - i_req_can = count<DEPTH.
  - d_req_can = count<DEPTH-1. One slot is always reserved for code misses.
  - Both depend only on registered state.
  - A request presented while its *_can is low is ignored.
- Dedup: an accepted request whose key matches any valid queued entry, or the in-flight key, is dropped silently. If i and d requests arrive in the same cycle with equal keys, only one is enqueued (the code one).
- Enqueue order on the same cycle: code entry first, then data entry. Both enter the tail in that order; count increases by up to 2.
- Issue:
  - new_en is registered. Next value = head valid && !in_flight && !(new_en && new_can) && !except.
  - new_* fields are driven from the head entry whenever new_en=1, and are held stable until accepted.
- Accept: new_en && new_can in a cycle causes, on the next edge:
  - head popped, count decremented;
  - in_flight=1, head key latched as in-flight key;
  - new_en=0.
- Completion: walk_done clears in_flight on the next edge. The next new_en can rise on the edge after that, giving minimum 2-cycle issue spacing after done. walk_done while in_flight=0 is ignored.
- except:
  - On the next edge all queued entries are invalidated, count=0 and new_en=0.
  - In-flight walk unaffected; walk_done still expected.
  - If new_en && new_can coincides with except, the handshake completes (in_flight set) and the remaining entries are flushed.
  - Requests arriving in the same cycle as except are discarded.
- Simultaneous enqueue and pop: count = count + enq - 1. Full/empty are judged on the registered count only.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH.
- busy = (count!=0) || in_flight, registered.
- Reset asserted mid-walk: all state cleared immediately. A walk_done arriving later while in_flight=0 is ignored.

Test Plan:
- Single code miss i_req_addr=48'h0000_1234_6000, new_can=1: new_en=1 two edges later with new_permReq=1, new_addr=48'h0000_1234_6000; after walk_done, busy=0.
- Same cycle i_req addr 48'h4000 and d_req addr 48'h8000 with walker idle: issue order is code (permReq=1) then data (permReq=0); second new_en rises 2 cycles after first walk_done.
- Dedup: d_req addr 48'h9000 queued, then d_req 48'h9ABC (same addr[47:14]=0x2, same attr): count stays 1, exactly one walk issued.
- Fill: with new_can=0, issue 3 data misses with distinct pages: d_req_can=0, i_req_can=1; a 4th code miss accepted, count=4, i_req_can=0.
- except with count=3 and walk in flight: count=0, new_en=0 next edge; the pending walk_done clears busy; no further new_en.
- Async reset asserted mid-walk, between accept and walk_done: all outputs 0 immediately; a late walk_done produces no issue.

Source files
------------

// File: rtl/tlb_miss_queue.sv
// Collects code/data TLB misses into a small FIFO, drops duplicate pages and
// feeds the page-table walker one walk at a time.
module tlb_miss_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             except,
   input  logic             i_req_en,
   input  logic [47:0]      i_req_addr,
   input  logic [3:0]       i_req_attr,
   output logic             i_req_can,
   input  logic             d_req_en,
   input  logic [47:0]      d_req_addr,
   input  logic [3:0]       d_req_attr,
   input  logic             d_req_indir,
   input  logic             d_req_inv,
   output logic             d_req_can,
   output logic             new_en,
   input  logic             new_can,
   output logic [47:0]      new_addr,
   output logic [3:0]       new_attr,
   output logic             new_indir,
   output logic             new_inv,
   output logic             new_permReq,
   input  logic             walk_done,
   output logic             busy,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int KEY_W = 40;
   localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] DLIM_C = CNT_W'(DEPTH - 1);

   // Page-granular key: two misses to the same 16 KiB page with identical attributes merge.
   function automatic logic [KEY_W-1:0] make_key(input logic [47:0] addr, input logic [3:0] attr,
                                                 input logic perm, input logic inv);
      return {addr[47:14], attr, perm, inv};
   endfunction

   logic [47:0]      addr_mem  [DEPTH];
   logic [3:0]       attr_mem  [DEPTH];
   logic             indir_mem [DEPTH];
   logic             inv_mem   [DEPTH];
   logic             perm_mem  [DEPTH];

   logic [DEPTH-1:0] valid_reg, valid_next;
   logic [PTR_W-1:0] head_reg, tail_reg, d_ptr;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             in_flight_reg, in_flight_next;
   logic [KEY_W-1:0] fl_key_reg;
   logic             new_en_reg, new_en_next;
   logic             busy_reg;
   logic [47:0]      new_addr_reg;
   logic [3:0]       new_attr_reg;
   logic             new_indir_reg, new_inv_reg, new_perm_reg;

   logic [KEY_W-1:0] i_key, d_key, head_key;
   logic [DEPTH-1:0] i_hit, d_hit;
   logic             i_ok, i_acc, d_acc, accept, head_valid;

   assign i_key      = make_key(i_req_addr, i_req_attr, 1'b1, 1'b0);
   assign d_key      = make_key(d_req_addr, d_req_attr, 1'b0, d_req_inv);
   assign head_valid = valid_reg[head_reg];
   assign head_key   = make_key(addr_mem[head_reg], attr_mem[head_reg],
                                perm_mem[head_reg], inv_mem[head_reg]);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
         logic [KEY_W-1:0] entry_key;
         assign entry_key = make_key(addr_mem[gi], attr_mem[gi], perm_mem[gi], inv_mem[gi]);
         assign i_hit[gi] = valid_reg[gi] && (entry_key == i_key);
         assign d_hit[gi] = valid_reg[gi] && (entry_key == d_key);
      end
   endgenerate

   assign i_req_can = (count_reg < FULL_C);
   assign d_req_can = (count_reg < DLIM_C);
   assign accept    = new_en_reg && new_can;

   // A code miss that is presented (even if itself a duplicate) suppresses an equal data miss.
   assign i_ok  = i_req_en && i_req_can && !except;
   assign i_acc = i_ok && !(|i_hit) && !(in_flight_reg && (fl_key_reg == i_key));
   assign d_acc = d_req_en && d_req_can && !except && !(|d_hit)
                  && !(in_flight_reg && (fl_key_reg == d_key))
                  && !(i_ok && (i_key == d_key));
   assign d_ptr = tail_reg + PTR_W'(i_acc);

   always_comb begin
      valid_next = valid_reg;
      if (accept)
         valid_next[head_reg] = 1'b0;
      if (i_acc)
         valid_next[tail_reg] = 1'b1;
      if (d_acc)
         valid_next[d_ptr] = 1'b1;
      if (except)
         valid_next = '0;
   end

   always_comb begin
      count_next = count_reg + CNT_W'(i_acc) + CNT_W'(d_acc) - CNT_W'(accept);
      if (except)
         count_next = '0;
   end

   assign in_flight_next = accept || (in_flight_reg && !walk_done);
   assign new_en_next    = head_valid && !in_flight_reg && !accept && !except;

   always_ff @(posedge clk) begin
      if (i_acc) begin
         addr_mem[tail_reg]  <= i_req_addr;
         attr_mem[tail_reg]  <= i_req_attr;
         indir_mem[tail_reg] <= 1'b0;
         inv_mem[tail_reg]   <= 1'b0;
         perm_mem[tail_reg]  <= 1'b1;
      end
      if (d_acc) begin
         addr_mem[d_ptr]  <= d_req_addr;
         attr_mem[d_ptr]  <= d_req_attr;
         indir_mem[d_ptr] <= d_req_indir;
         inv_mem[d_ptr]   <= d_req_inv;
         perm_mem[d_ptr]  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_reg     <= '0;
         head_reg      <= '0;
         tail_reg      <= '0;
         count_reg     <= '0;
         in_flight_reg <= 1'b0;
         fl_key_reg    <= '0;
         new_en_reg    <= 1'b0;
         busy_reg      <= 1'b0;
         new_addr_reg  <= '0;
         new_attr_reg  <= '0;
         new_indir_reg <= 1'b0;
         new_inv_reg   <= 1'b0;
         new_perm_reg  <= 1'b0;
      end else begin
         valid_reg     <= valid_next;
         count_reg     <= count_next;
         in_flight_reg <= in_flight_next;
         busy_reg      <= (count_next != '0) || in_flight_next;
         new_en_reg    <= new_en_next;
         if (accept)
            fl_key_reg <= head_key;
         if (except) begin
            head_reg <= '0;
            tail_reg <= '0;
         end else begin
            head_reg <= head_reg + PTR_W'(accept);
            tail_reg <= tail_reg + PTR_W'(i_acc) + PTR_W'(d_acc);
         end
         // Head cannot change while new_en is high, so reloading keeps the fields stable.
         if (new_en_next) begin
            new_addr_reg  <= addr_mem[head_reg];
            new_attr_reg  <= attr_mem[head_reg];
            new_indir_reg <= indir_mem[head_reg];
            new_inv_reg   <= inv_mem[head_reg];
            new_perm_reg  <= perm_mem[head_reg];
         end
      end
   end

   assign new_en      = new_en_reg;
   assign new_addr    = new_addr_reg;
   assign new_attr    = new_attr_reg;
   assign new_indir   = new_indir_reg;
   assign new_inv     = new_inv_reg;
   assign new_permReq = new_perm_reg;
   assign busy        = busy_reg;
   assign count       = count_reg;

endmodule

// File: tb/tb_tlb_miss_queue.sv
// Directed bench for tlb_miss_queue: issue order, dedup, capacity, flush and reset.
module tb_tlb_miss_queue;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        except = 1'b0;
   logic        i_req_en = 1'b0;
   logic [47:0] i_req_addr = '0;
   logic [3:0]  i_req_attr = '0;
   logic        i_req_can;
   logic        d_req_en = 1'b0;
   logic [47:0] d_req_addr = '0;
   logic [3:0]  d_req_attr = '0;
   logic        d_req_indir = 1'b0;
   logic        d_req_inv = 1'b0;
   logic        d_req_can;
   logic        new_en;
   logic        new_can = 1'b0;
   logic [47:0] new_addr;
   logic [3:0]  new_attr;
   logic        new_indir, new_inv, new_permReq;
   logic        walk_done = 1'b0;
   logic        busy;
   logic [2:0]  count;

   int pass_cnt = 0;
   int total_cnt = 0;

   tlb_miss_queue #(.DEPTH(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .except(except),
      .i_req_en(i_req_en), .i_req_addr(i_req_addr), .i_req_attr(i_req_attr), .i_req_can(i_req_can),
      .d_req_en(d_req_en), .d_req_addr(d_req_addr), .d_req_attr(d_req_attr),
      .d_req_indir(d_req_indir), .d_req_inv(d_req_inv), .d_req_can(d_req_can),
      .new_en(new_en), .new_can(new_can), .new_addr(new_addr), .new_attr(new_attr),
      .new_indir(new_indir), .new_inv(new_inv), .new_permReq(new_permReq),
      .walk_done(walk_done), .busy(busy), .count(count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      total_cnt++; if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
      total_cnt++; if (new_en !== 1'b0) $display("FAIL reset_new_en: got %b expected 0", new_en); else pass_cnt++;
      total_cnt++; if (new_addr !== 48'h0) $display("FAIL reset_new_addr: got %h expected 0", new_addr); else pass_cnt++;
      total_cnt++; if ({i_req_can, d_req_can} !== 2'b11) $display("FAIL reset_can: got %b expected 11", {i_req_can, d_req_can}); else pass_cnt++;
      @(posedge clk);
      #4 rst = 1'b1;
      tick();
      $display("test_reset: released");
   endtask

   task automatic test_single_code();
      new_can = 1'b1;
      i_req_en = 1'b1; i_req_addr = 48'h0000_1234_6000; i_req_attr = 4'h3;
      tick();
      i_req_en = 1'b0;
      total_cnt++; if (count !== 3'd1) $display("FAIL single_count: got %0d expected 1", count); else pass_cnt++;
      total_cnt++; if (new_en !== 1'b0) $display("FAIL single_early_en: got %b expected 0", new_en); else pass_cnt++;
      tick();
      total_cnt++; if (new_en !== 1'b1) $display("FAIL single_new_en: got %b expected 1", new_en); else pass_cnt++;
      total_cnt++; if (new_permReq !== 1'b1) $display("FAIL single_perm: got %b expected 1", new_permReq); else pass_cnt++;
      total_cnt++; if (new_addr !== 48'h0000_1234_6000) $display("FAIL single_addr: got %h expected 000012346000", new_addr); else pass_cnt++;
      total_cnt++; if (new_attr !== 4'h3) $display("FAIL single_attr: got %h expected 3", new_attr); else pass_cnt++;
      tick();
      total_cnt++; if ({new_en, count, busy} !== {1'b0, 3'd0, 1'b1}) $display("FAIL single_accept: got en/cnt/busy %b/%0d/%b expected 0/0/1", new_en, count, busy); else pass_cnt++;
      walk_done = 1'b1;
      tick();
      walk_done = 1'b0;
      total_cnt++; if (busy !== 1'b0) $display("FAIL single_done_busy: got %b expected 0", busy); else pass_cnt++;
      $display("test_single_code: addr=%h", 48'h0000_1234_6000);
   endtask

   task automatic test_order();
      new_can = 1'b1;
      i_req_en = 1'b1; i_req_addr = 48'h4000; i_req_attr = 4'h0;
      d_req_en = 1'b1; d_req_addr = 48'h8000; d_req_attr = 4'h0;
      tick();
      i_req_en = 1'b0; d_req_en = 1'b0;
      total_cnt++; if (count !== 3'd2) $display("FAIL order_count: got %0d expected 2", count); else pass_cnt++;
      tick();
      total_cnt++; if ({new_en, new_permReq} !== 2'b11) $display("FAIL order_first_perm: got en/perm %b expected 11", {new_en, new_permReq}); else pass_cnt++;
      total_cnt++; if (new_addr !== 48'h4000) $display("FAIL order_first_addr: got %h expected 4000", new_addr); else pass_cnt++;
      tick();
      tick();
      total_cnt++; if ({new_en, count} !== {1'b0, 3'd1}) $display("FAIL order_hold: got en/cnt %b/%0d expected 0/1", new_en, count); else pass_cnt++;
      walk_done = 1'b1;
      tick();
      walk_done = 1'b0;
      total_cnt++; if (new_en !== 1'b0) $display("FAIL order_spacing: got %b expected 0", new_en); else pass_cnt++;
      tick();
      total_cnt++; if ({new_en, new_permReq} !== 2'b10) $display("FAIL order_second_perm: got en/perm %b expected 10", {new_en, new_permReq}); else pass_cnt++;
      total_cnt++; if (new_addr !== 48'h8000) $display("FAIL order_second_addr: got %h expected 8000", new_addr); else pass_cnt++;
      tick();
      total_cnt++; if ({new_en, count} !== {1'b0, 3'd0}) $display("FAIL order_second_accept: got en/cnt %b/%0d expected 0/0", new_en, count); else pass_cnt++;
      walk_done = 1'b1;
      tick();
      walk_done = 1'b0;
      total_cnt++; if (busy !== 1'b0) $display("FAIL order_idle: got %b expected 0", busy); else pass_cnt++;
      $display("test_order: code 4000 then data 8000");
   endtask

   task automatic test_dedup();
      int issues = 0;
      new_can = 1'b0;
      d_req_en = 1'b1; d_req_addr = 48'h9000; d_req_attr = 4'h1; d_req_indir = 1'b1;
      tick();
      d_req_addr = 48'h9ABC; d_req_indir = 1'b0;
      tick();
      d_req_en = 1'b0;
      total_cnt++; if (count !== 3'd1) $display("FAIL dedup_queued: got %0d expected 1", count); else pass_cnt++;
      total_cnt++; if ({new_en, new_indir} !== 2'b11) $display("FAIL dedup_head: got en/indir %b expected 11", {new_en, new_indir}); else pass_cnt++;
      total_cnt++; if (new_addr !== 48'h9000) $display("FAIL dedup_addr: got %h expected 9000", new_addr); else pass_cnt++;
      new_can = 1'b1;
      tick();
      new_can = 1'b0;
      d_req_en = 1'b1; d_req_addr = 48'h9ABC;
      tick();
      d_req_en = 1'b0;
      total_cnt++; if (count !== 3'd0) $display("FAIL dedup_inflight: got %0d expected 0", count); else pass_cnt++;
      walk_done = 1'b1;
      tick();
      walk_done = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (new_en) issues++;
      end
      total_cnt++; if (issues !== 0) $display("FAIL dedup_extra_walks: got %0d expected 0", issues); else pass_cnt++;
      $display("test_dedup: 9000/9ABC merged");
   endtask

   task automatic test_fill();
      new_can = 1'b0;
      d_req_en = 1'b1; d_req_attr = 4'h2;
      d_req_addr = 48'h10000; tick();
      d_req_addr = 48'h20000; tick();
      d_req_addr = 48'h30000; tick();
      d_req_en = 1'b0;
      total_cnt++; if (count !== 3'd3) $display("FAIL fill_count3: got %0d expected 3", count); else pass_cnt++;
      total_cnt++; if ({i_req_can, d_req_can} !== 2'b10) $display("FAIL fill_can3: got i/d %b expected 10", {i_req_can, d_req_can}); else pass_cnt++;
      total_cnt++; if (new_addr !== 48'h10000) $display("FAIL fill_head: got %h expected 10000", new_addr); else pass_cnt++;
      i_req_en = 1'b1; i_req_addr = 48'h50000; i_req_attr = 4'h0;
      d_req_en = 1'b1; d_req_addr = 48'h40000;
      tick();
      i_req_en = 1'b0; d_req_en = 1'b0;
      total_cnt++; if (count !== 3'd4) $display("FAIL fill_count4: got %0d expected 4", count); else pass_cnt++;
      total_cnt++; if ({i_req_can, d_req_can} !== 2'b00) $display("FAIL fill_can4: got i/d %b expected 00", {i_req_can, d_req_can}); else pass_cnt++;
      $display("test_fill: 3 data + 1 code");
   endtask

   task automatic test_except();
      int issues = 0;
      new_can = 1'b1;
      tick();
      new_can = 1'b0;
      total_cnt++; if ({new_en, count, busy} !== {1'b0, 3'd3, 1'b1}) $display("FAIL except_pre: got en/cnt/busy %b/%0d/%b expected 0/3/1", new_en, count, busy); else pass_cnt++;
      except = 1'b1;
      i_req_en = 1'b1; i_req_addr = 48'h60000;
      tick();
      except = 1'b0; i_req_en = 1'b0;
      total_cnt++; if ({new_en, count, busy} !== {1'b0, 3'd0, 1'b1}) $display("FAIL except_flush: got en/cnt/busy %b/%0d/%b expected 0/0/1", new_en, count, busy); else pass_cnt++;
      total_cnt++; if (d_req_can !== 1'b1) $display("FAIL except_dcan: got %b expected 1", d_req_can); else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (new_en) issues++;
      end
      walk_done = 1'b1;
      tick();
      walk_done = 1'b0;
      total_cnt++; if ({busy, count} !== {1'b0, 3'd0}) $display("FAIL except_done: got busy/cnt %b/%0d expected 0/0", busy, count); else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (new_en) issues++;
      end
      total_cnt++; if (issues !== 0) $display("FAIL except_no_issue: got %0d expected 0", issues); else pass_cnt++;
      $display("test_except: flushed 3 entries");
   endtask

   task automatic test_async_reset();
      int issues = 0;
      new_can = 1'b1;
      i_req_en = 1'b1; i_req_addr = 48'hA000; i_req_attr = 4'h1;
      d_req_en = 1'b1; d_req_addr = 48'hC000; d_req_attr = 4'h1;
      tick();
      i_req_en = 1'b0; d_req_en = 1'b0;
      tick();
      total_cnt++; if ({new_en, new_permReq} !== 2'b11) $display("FAIL arst_issue: got en/perm %b expected 11", {new_en, new_permReq}); else pass_cnt++;
      tick();
      total_cnt++; if ({busy, count} !== {1'b1, 3'd1}) $display("FAIL arst_inflight: got busy/cnt %b/%0d expected 1/1", busy, count); else pass_cnt++;
      #2 rst = 1'b0;
      #1;
      total_cnt++; if ({busy, new_en, count} !== {1'b0, 1'b0, 3'd0}) $display("FAIL arst_clear: got busy/en/cnt %b/%b/%0d expected 0/0/0", busy, new_en, count); else pass_cnt++;
      total_cnt++; if ({new_addr, new_permReq} !== 49'h0) $display("FAIL arst_fields: got addr/perm %h/%b expected 0/0", new_addr, new_permReq); else pass_cnt++;
      #1 rst = 1'b1;
      walk_done = 1'b1;
      tick();
      walk_done = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (new_en) issues++;
      end
      total_cnt++; if (issues !== 0) $display("FAIL arst_late_done: got %0d expected 0", issues); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b expected 0", busy); else pass_cnt++;
      $display("test_async_reset: mid-walk reset");
   endtask

   initial begin
      test_reset();
      test_single_code();
      test_order();
      test_dedup();
      test_fill();
      test_except();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1);
   end
endmodule
